// File: rtl/goose_sprite_sched.sv
// Sprite scheduler for the VGA goose: beam -> 32x32 LUT address, frame select, bounce motion.
// Latency: hpos/vpos to pix_valid/pix_index is 2 cycles; frame/position update the cycle after vsync_tick.
// Backpressure: none, free-running with the pixel clock. Optional mirroring via GOOSE_MIRROR_EN.
module goose_sprite_sched #(
    parameter int NUM_FRAMES  = 8,
    parameter int HOLD_TICKS  = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int STEP        = 2,
    parameter int X0          = 288,
    parameter int Y0          = 208
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [9:0]                    hpos,
    input  logic [9:0]                    vpos,
    input  logic                          display_on,
    input  logic                          vsync_tick,
    input  logic                          spin_req,
    output logic [4:0]                    lut_x,
    output logic [4:0]                    lut_y,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_sel,
    input  logic [2:0]                    lut_pixel,
    output logic                          pix_valid,
    output logic [2:0]                    pix_index,
    output logic [9:0]                    sprite_x,
    output logic [9:0]                    sprite_y,
    output logic                          busy
);

    localparam int FW = $clog2(NUM_FRAMES);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [10:0]   WID        = 11'(32 << SCALE_SHIFT);
    localparam logic [9:0]    XMAX       = 10'(640 - (32 << SCALE_SHIFT));
    localparam logic [9:0]    YMAX       = 10'(480 - (32 << SCALE_SHIFT));
    localparam logic [9:0]    STEP_V     = 10'(STEP);
    localparam logic [HW-1:0] LAST_HOLD  = HW'(HOLD_TICKS - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d, hold_adv;
    logic [FW-1:0] frame_d, frame_adv;
    logic [9:0]    x_d, y_d, x_mv, y_mv;
    logic          dir_x_q, dir_y_q, dir_x_d, dir_y_d, dir_x_mv, dir_y_mv;

    logic [9:0]    rx, ry;
    logic [9:0]    rx_s, ry_s;
    logic [4:0]    lut_x_d;
    logic          inside_d, inside_q;

    // Beam-relative offsets against the current (pre-update) origin.
    always_comb begin
        rx       = hpos - sprite_x;
        ry       = vpos - sprite_y;
        rx_s     = rx >> SCALE_SHIFT;
        ry_s     = ry >> SCALE_SHIFT;
        inside_d = display_on & ({1'b0, rx} < WID) & ({1'b0, ry} < WID);
`ifdef GOOSE_MIRROR_EN
        // dir_x_q is 0 while moving left; the goose then faces the other way.
        lut_x_d  = dir_x_q ? rx_s[4:0] : (5'd31 - rx_s[4:0]);
`else
        lut_x_d  = rx_s[4:0];
`endif
    end

    // Stage 1: LUT address and inside flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_x    <= '0;
            lut_y    <= '0;
            inside_q <= 1'b0;
        end else begin
            lut_x    <= lut_x_d;
            lut_y    <= ry_s[4:0];
            inside_q <= inside_d;
        end
    end

    // Stage 2: register the returned palette index; index 0 and off-sprite are invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_index <= '0;
        end else begin
            pix_valid <= inside_q & (lut_pixel != 3'd0);
            pix_index <= inside_q ? lut_pixel : 3'd0;
        end
    end

    // Hold counter / frame advance shared by SPIN and STOP.
    always_comb begin
        hold_adv  = hold_q + HW'(1);
        frame_adv = frame_sel;
        if (hold_q == LAST_HOLD) begin
            hold_adv  = '0;
            frame_adv = (frame_sel == LAST_FRAME) ? '0 : frame_sel + FW'(1);
        end
    end

    // Bounce motion: reaching an edge clamps to it and turns that axis around.
    always_comb begin
        x_mv     = sprite_x;
        y_mv     = sprite_y;
        dir_x_mv = dir_x_q;
        dir_y_mv = dir_y_q;
        if (dir_x_q) begin
            if (({1'b0, sprite_x} + {1'b0, STEP_V}) >= {1'b0, XMAX}) begin
                x_mv     = XMAX;
                dir_x_mv = 1'b0;
            end else begin
                x_mv = sprite_x + STEP_V;
            end
        end else if (sprite_x <= STEP_V) begin
            x_mv     = '0;
            dir_x_mv = 1'b1;
        end else begin
            x_mv = sprite_x - STEP_V;
        end
        if (dir_y_q) begin
            if (({1'b0, sprite_y} + {1'b0, STEP_V}) >= {1'b0, YMAX}) begin
                y_mv     = YMAX;
                dir_y_mv = 1'b0;
            end else begin
                y_mv = sprite_y + STEP_V;
            end
        end else if (sprite_y <= STEP_V) begin
            y_mv     = '0;
            dir_y_mv = 1'b1;
        end else begin
            y_mv = sprite_y - STEP_V;
        end
    end

    // Next-state logic; everything holds except on vsync_tick so frames never tear.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        frame_d = frame_sel;
        x_d     = sprite_x;
        y_d     = sprite_y;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (vsync_tick) begin
            case (state_q)
                IDLE: begin
                    if (spin_req) begin
                        state_d = SPIN;
                        hold_d  = '0;
                    end
                end
                SPIN: begin
                    hold_d  = hold_adv;
                    frame_d = frame_adv;
                    x_d     = x_mv;
                    y_d     = y_mv;
                    dir_x_d = dir_x_mv;
                    dir_y_d = dir_y_mv;
                    if (!spin_req) state_d = STOP;
                end
                STOP: begin
                    hold_d  = hold_adv;
                    frame_d = frame_adv;
                    if (spin_req) begin
                        state_d = SPIN;
                    end else if ((frame_adv == '0) && (frame_sel != '0)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, animation and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            frame_sel <= '0;
            sprite_x  <= 10'(X0);
            sprite_y  <= 10'(Y0);
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            frame_sel <= frame_d;
            sprite_x  <= x_d;
            sprite_y  <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: doc/goose_sprite_sched.md
Name: goose_sprite_sched

Overview:
- Sequences the shared 32×32 sprite frame LUT bank for the VGA goose animation.
- Maps beam coordinates to LUT (x,y) and selects which animation frame drives the shared LUT address bus.
- Advances frames and bounces the sprite position only at vertical-blank ticks, so frames never tear.
- Pipelines the returned 3-bit palette index to the colour stage, marking transparency and off-sprite pixels as invalid.

Parameters:
- NUM_FRAMES, 8: animation frames in the LUT bank; frame_sel counts 0..NUM_FRAMES-1.
- HOLD_TICKS, 4: vsync ticks each frame is displayed while spinning; must be ≥1.
- SCALE_SHIFT, 1: sprite is drawn at 32<<SCALE_SHIFT pixels square.
- STEP, 2: pixels moved per vsync tick on each axis while spinning.
- X0, 288: reset sprite origin x.
- Y0, 208: reset sprite origin y.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hpos  in  10  beam x, 0..639 visible
- vpos  in  10  beam y, 0..479 visible
- display_on  in  1  beam in visible area
- vsync_tick  in  1  one-cycle pulse at start of vertical blanking
- spin_req  in  1  level request to animate
- lut_x  out  5  LUT column address
- lut_y  out  5  LUT row address
- frame_sel  out  $clog2(NUM_FRAMES)  frame selecting the LUT driving lut_pixel
- lut_pixel  in  3  palette index returned combinationally for lut_x/lut_y/frame_sel
- pix_valid  out  1  opaque sprite pixel present
- pix_index  out  3  palette index, meaningful when pix_valid=1
- sprite_x  out  10  current origin x
- sprite_y  out  10  current origin y
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync deassert):
  - all outputs 0 except sprite_x=X0 and sprite_y=Y0.
  - FSM enters IDLE; hold counter = 0; x and y directions = +.
- Stage 1, registered:
  - rx = hpos - sprite_x, ry = vpos - sprite_y, computed 10-bit unsigned.
  - inside = display_on & rx < (32<<SCALE_SHIFT) & ry < (32<<SCALE_SHIFT).
  - lut_x = rx>>SCALE_SHIFT, lut_y = ry>>SCALE_SHIFT, truncated to 5 bits.
  - Register inside alongside the addresses.
- Stage 2, registered:
  - pix_index = lut_pixel.
  - pix_valid = inside_q & (lut_pixel != 0); index 0 is transparent.
  - When pix_valid=0, pix_index = 0.
- Latency: hpos/vpos to pix_valid/pix_index is exactly 2 cycles.
- frame_sel, sprite_x and sprite_y change only in the cycle after vsync_tick. They are constant across the whole visible frame.
- FSM, evaluated only on vsync_tick (no state change on other cycles):
  - IDLE: frame_sel held at 0, no movement. spin_req=1 → SPIN, with hold counter cleared.
  - SPIN: hold counter increments each tick. On reaching HOLD_TICKS-1 it clears and frame_sel advances, wrapping NUM_FRAMES-1 → 0. Position moves by STEP every tick. spin_req=0 → STOP.
  - STOP: keeps advancing frames as in SPIN, but without movement.
    - Entering frame 0 → IDLE.
    - spin_req=1 re-asserted → SPIN; this has priority over returning to IDLE.
- Bounce, with W = 32<<SCALE_SHIFT:
  - x range is 0..640-W, y range is 0..480-W.
  - If the next position would leave the range, clamp to the limit and flip that axis's direction in the same update.
  - x and y are handled independently.
- Simultaneous: vsync_tick during a visible pixel still registers that pixel with the pre-update frame_sel and position.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: GOOSE_MIRROR_EN.
- Defined: while x direction is negative, lut_x = 31 - (rx>>SCALE_SHIFT), mirroring the goose horizontally. Mirroring toggles only with a direction flip, so only at vsync_tick.
- Undefined: lut_x is never mirrored; the direction register still exists for bouncing.

Test Plan:
- Reset mid-frame with spin_req=1 → on release: sprite_x=288, sprite_y=208, frame_sel=0, busy=0, pix_valid=0.
- IDLE sweep, SCALE_SHIFT=1 → hpos=288,vpos=208 gives lut_x=0,lut_y=0 two cycles later; hpos=351 gives lut_x=31; hpos=352 gives pix_valid=0; lut_pixel=0 gives pix_valid=0.
- spin_req=1, HOLD_TICKS=4 → frame_sel steps 0→1 after the 4th tick post-entry; after 32 ticks frame_sel wraps to 0; sprite_x advances 2 per tick.
- Sprite at x=574 moving + with STEP=2, W=64 → next tick clamps sprite_x=576, direction flips; following tick sprite_x=574.
- Drop spin_req at frame_sel=5 → frames 6,7 still shown (busy=1), at frame 0 busy=0; re-raise at frame 6 → stays SPIN.
- GOOSE_MIRROR_EN, moving left → hpos=sprite_x gives lut_x=31.
